// File: rtl/memory_access_stage.sv
// MIPS M stage with M/W pipeline register; loads/stores go out over a req/ack bus with a timeout.
// Optional MEM_ALIGN_CHECK_EN rejects word-misaligned memory ops without touching the bus.
module memory_access_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_TIMEOUT    = 15
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_ValidM,
  input  logic [DATA_WIDTH-1:0]     i_ALUOutM,
  input  logic [DATA_WIDTH-1:0]     i_WriteDataM,
  input  logic [REG_ADDR_WIDTH-1:0] i_WriteRegM,
  input  logic                      i_MemtoRegM,
  input  logic                      i_MemWriteM,
  input  logic                      i_RegWriteM,
  output logic                      o_StallM,
  output logic                      o_mem_req,
  output logic                      o_mem_we,
  output logic [DATA_WIDTH-1:0]     o_mem_addr,
  output logic [DATA_WIDTH-1:0]     o_mem_wdata,
  input  logic                      i_mem_ack,
  input  logic [DATA_WIDTH-1:0]     i_mem_rdata,
  output logic                      o_mem_err,
  output logic                      o_ValidW,
  output logic [DATA_WIDTH-1:0]     o_ALUOutW,
  output logic [DATA_WIDTH-1:0]     o_ReadDataW,
  output logic [REG_ADDR_WIDTH-1:0] o_WriteRegW,
  output logic                      o_MemtoRegW,
  output logic                      o_RegWriteW
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             mem_op;
  logic             misaligned;

  assign mem_op = i_ValidM & (i_MemtoRegM | i_MemWriteM);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = mem_op & (i_ALUOutM[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    o_StallM = 1'b0;
    if (i_rst_n) begin
      if (state == IDLE) o_StallM = mem_op & ~misaligned;
      else               o_StallM = ~i_mem_ack;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_err   <= 1'b0;
      o_ValidW    <= 1'b0;
      o_ALUOutW   <= '0;
      o_ReadDataW <= '0;
      o_WriteRegW <= '0;
      o_MemtoRegW <= 1'b0;
      o_RegWriteW <= 1'b0;
    end else begin
      o_mem_err <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_op && !misaligned) begin
            state       <= ACCESS;
            cnt         <= '0;
            o_mem_req   <= 1'b1;
            o_mem_we    <= i_MemWriteM;
            o_mem_addr  <= i_ALUOutM;
            o_mem_wdata <= i_WriteDataM;
            o_ValidW    <= 1'b0;
            o_RegWriteW <= 1'b0;
          end else begin
            // Plain pass-through; a misaligned op is retired as a dead instruction with an error.
            o_ValidW    <= i_ValidM;
            o_ALUOutW   <= i_ALUOutM;
            o_WriteRegW <= i_WriteRegM;
            o_MemtoRegW <= i_MemtoRegM;
            o_RegWriteW <= i_ValidM & i_RegWriteM & ~misaligned;
            o_mem_err   <= misaligned;
          end
        end
        ACCESS: begin
          if (i_mem_ack || cnt == CNT_LAST) begin
            state       <= IDLE;
            o_mem_req   <= 1'b0;
            o_ValidW    <= 1'b1;
            o_ALUOutW   <= i_ALUOutM;
            o_WriteRegW <= i_WriteRegM;
            o_MemtoRegW <= i_MemtoRegM;
            if (i_mem_ack) begin
              o_RegWriteW <= i_RegWriteM;
              if (!o_mem_we) o_ReadDataW <= i_mem_rdata;
            end else begin
              o_RegWriteW <= 1'b0;
              o_mem_err   <= 1'b1;
            end
          end else begin
            cnt         <= cnt + CNT_W'(1);
            o_ValidW    <= 1'b0;
            o_RegWriteW <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: ALU pass-through, load/store handshakes, timeout,
// reset during a bus access, alignment handling and back-to-back memory ops.
module tb_memory_access_stage;
  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_m, memtoreg_m, memwrite_m, regwrite_m;
  logic [DW-1:0] aluout_m, wdata_m;
  logic [RW-1:0] writereg_m;
  logic          stall, mem_req, mem_we, mem_ack, mem_err;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
  logic          valid_w, memtoreg_w, regwrite_w;
  logic [DW-1:0] aluout_w, readdata_w;
  logic [RW-1:0] writereg_w;

  int pass_cnt  = 0;
  int total_cnt = 0;

  memory_access_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .MEM_TIMEOUT(15)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ValidM(valid_m), .i_ALUOutM(aluout_m),
    .i_WriteDataM(wdata_m), .i_WriteRegM(writereg_m), .i_MemtoRegM(memtoreg_m),
    .i_MemWriteM(memwrite_m), .i_RegWriteM(regwrite_m), .o_StallM(stall),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata), .o_mem_err(mem_err),
    .o_ValidW(valid_w), .o_ALUOutW(aluout_w), .o_ReadDataW(readdata_w),
    .o_WriteRegW(writereg_w), .o_MemtoRegW(memtoreg_w), .o_RegWriteW(regwrite_w)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_m();
    valid_m = 0; memtoreg_m = 0; memwrite_m = 0; regwrite_m = 0;
    aluout_m = '0; wdata_m = '0; writereg_m = '0;
  endtask

  task automatic drive_load(input logic [DW-1:0] addr, input logic [RW-1:0] rd);
    valid_m = 1; memtoreg_m = 1; memwrite_m = 0; regwrite_m = 1;
    aluout_m = addr; wdata_m = '0; writereg_m = rd;
  endtask

  task automatic test_reset();
    rst_n = 0; mem_ack = 0; mem_rdata = '0;
    clear_m();
    step(); step();
    drive_load(32'h100, 5'd3);
    #1;
    total_cnt++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else pass_cnt++;
    total_cnt++; if (mem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", mem_req); else pass_cnt++;
    total_cnt++; if ({valid_w, regwrite_w, memtoreg_w, mem_err} !== 4'b0)
      $display("FAIL reset_ctrl_w: got %b want 0000", {valid_w, regwrite_w, memtoreg_w, mem_err}); else pass_cnt++;
    total_cnt++; if (aluout_w !== '0 || readdata_w !== '0 || mem_addr !== '0)
      $display("FAIL reset_data: got %h/%h/%h want 0", aluout_w, readdata_w, mem_addr); else pass_cnt++;
    clear_m();
    rst_n = 1;
    step();
  endtask

  task automatic test_alu();
    valid_m = 1; regwrite_m = 1; aluout_m = 32'h10; writereg_m = 5'd8;
    #1;
    total_cnt++; if (stall !== 1'b0) $display("FAIL alu_stall: got %b want 0", stall); else pass_cnt++;
    step();
    total_cnt++; if (aluout_w !== 32'h10) $display("FAIL alu_out: got %h want 00000010", aluout_w); else pass_cnt++;
    total_cnt++; if ({valid_w, regwrite_w, memtoreg_w, writereg_w} !== {3'b110, 5'd8})
      $display("FAIL alu_ctrl: got %b want 11001000", {valid_w, regwrite_w, memtoreg_w, writereg_w}); else pass_cnt++;
    clear_m();
    step();
    total_cnt++; if ({valid_w, regwrite_w} !== 2'b00)
      $display("FAIL alu_invalid_slot: got %b want 00", {valid_w, regwrite_w}); else pass_cnt++;
  endtask

  task automatic test_load();
    int stall_cycles = 0;
    drive_load(32'h100, 5'd9);
    #1;
    if (stall) stall_cycles++;
    total_cnt++; if (mem_req !== 1'b0) $display("FAIL load_req_idle: got %b want 0", mem_req); else pass_cnt++;
    step();
    for (int c = 1; c <= 3; c++) begin
      #1;
      if (stall) stall_cycles++;
      total_cnt++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h100})
        $display("FAIL load_bus_c%0d: got req=%b we=%b addr=%h want 1/0/00000100", c, mem_req, mem_we, mem_addr); else pass_cnt++;
      total_cnt++; if ({valid_w, regwrite_w} !== 2'b00)
        $display("FAIL load_bubble_c%0d: got %b want 00", c, {valid_w, regwrite_w}); else pass_cnt++;
      step();
    end
    mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    if (stall) stall_cycles++;
    total_cnt++; if (stall_cycles != 4) $display("FAIL load_stall_len: got %0d want 4", stall_cycles); else pass_cnt++;
    step();
    mem_ack = 0; mem_rdata = '0;
    clear_m();
    total_cnt++; if (readdata_w !== 32'hDEAD_BEEF) $display("FAIL load_rdata: got %h want deadbeef", readdata_w); else pass_cnt++;
    total_cnt++; if ({valid_w, memtoreg_w, regwrite_w, writereg_w, mem_req} !== {3'b111, 5'd9, 1'b0})
      $display("FAIL load_commit: got %b want 111010010", {valid_w, memtoreg_w, regwrite_w, writereg_w, mem_req}); else pass_cnt++;
    step();
  endtask

  task automatic test_store();
    valid_m = 1; memwrite_m = 1; aluout_m = 32'h200; wdata_m = 32'h1234; writereg_m = 5'd4;
    #1;
    total_cnt++; if (stall !== 1'b1) $display("FAIL store_stall_idle: got %b want 1", stall); else pass_cnt++;
    step();
    mem_ack = 1;
    #1;
    total_cnt++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h200, 32'h1234})
      $display("FAIL store_bus: got req=%b we=%b addr=%h wdata=%h want 1/1/00000200/00001234", mem_req, mem_we, mem_addr, mem_wdata); else pass_cnt++;
    total_cnt++; if (stall !== 1'b0) $display("FAIL store_stall_ack: got %b want 0", stall); else pass_cnt++;
    step();
    mem_ack = 0;
    clear_m();
    total_cnt++; if ({valid_w, regwrite_w, mem_req} !== 3'b100)
      $display("FAIL store_commit: got %b want 100", {valid_w, regwrite_w, mem_req}); else pass_cnt++;
    total_cnt++; if (readdata_w !== 32'hDEAD_BEEF) $display("FAIL store_rdata_hold: got %h want deadbeef", readdata_w); else pass_cnt++;
    step();
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    int early_err  = 0;
    drive_load(32'h300, 5'd10);
    step();
    for (int i = 0; i < 40; i++) begin
      if (!mem_req) break;
      req_cycles++;
      if (mem_err) early_err++;
      step();
    end
    clear_m();
    total_cnt++; if (req_cycles != 15) $display("FAIL timeout_req_len: got %0d want 15", req_cycles); else pass_cnt++;
    total_cnt++; if (early_err != 0) $display("FAIL timeout_early_err: got %0d want 0", early_err); else pass_cnt++;
    total_cnt++; if ({mem_err, valid_w, regwrite_w, writereg_w} !== {3'b110, 5'd10})
      $display("FAIL timeout_commit: got %b want 11001010", {mem_err, valid_w, regwrite_w, writereg_w}); else pass_cnt++;
    step();
    total_cnt++; if ({mem_err, mem_req} !== 2'b00)
      $display("FAIL timeout_err_pulse: got %b want 00", {mem_err, mem_req}); else pass_cnt++;
  endtask

  task automatic test_reset_mid_access();
    drive_load(32'h400, 5'd12);
    step(); step();
    rst_n = 0;
    #1;
    total_cnt++; if (stall !== 1'b0) $display("FAIL rstmid_stall: got %b want 0", stall); else pass_cnt++;
    step();
    total_cnt++; if ({mem_req, valid_w, regwrite_w, memtoreg_w, writereg_w} !== 9'b0)
      $display("FAIL rstmid_ctrl: got %b want 0", {mem_req, valid_w, regwrite_w, memtoreg_w, writereg_w}); else pass_cnt++;
    total_cnt++; if (aluout_w !== '0 || readdata_w !== '0)
      $display("FAIL rstmid_data: got %h/%h want 0/0", aluout_w, readdata_w); else pass_cnt++;
    rst_n = 1;
    clear_m();
    mem_ack = 1; mem_rdata = 32'h5555_5555;
    step();
    mem_ack = 0; mem_rdata = '0;
    total_cnt++; if ({mem_req, valid_w, mem_err} !== 3'b000 || readdata_w !== '0)
      $display("FAIL rstmid_late_ack: got ctrl=%b rdata=%h want 000/0", {mem_req, valid_w, mem_err}, readdata_w); else pass_cnt++;
  endtask

  task automatic test_align();
    drive_load(32'h102, 5'd11);
    #1;
`ifdef MEM_ALIGN_CHECK_EN
    total_cnt++; if (stall !== 1'b0) $display("FAIL align_stall: got %b want 0", stall); else pass_cnt++;
    step();
    clear_m();
    total_cnt++; if ({mem_req, mem_err, valid_w, regwrite_w} !== 4'b0110)
      $display("FAIL align_commit: got %b want 0110", {mem_req, mem_err, valid_w, regwrite_w}); else pass_cnt++;
    step();
    total_cnt++; if ({mem_req, mem_err} !== 2'b00) $display("FAIL align_after: got %b want 00", {mem_req, mem_err}); else pass_cnt++;
`else
    total_cnt++; if (stall !== 1'b1) $display("FAIL align_stall: got %b want 1", stall); else pass_cnt++;
    step();
    total_cnt++; if ({mem_req, mem_addr} !== {1'b1, 32'h102})
      $display("FAIL align_passthru: got req=%b addr=%h want 1/00000102", mem_req, mem_addr); else pass_cnt++;
    mem_ack = 1; mem_rdata = 32'hA5A5_0001;
    step();
    mem_ack = 0;
    clear_m();
    total_cnt++; if ({valid_w, regwrite_w, mem_err, mem_req} !== 4'b1100 || readdata_w !== 32'hA5A5_0001)
      $display("FAIL align_commit: got ctrl=%b rdata=%h want 1100/a5a50001", {valid_w, regwrite_w, mem_err, mem_req}, readdata_w); else pass_cnt++;
    step();
`endif
  endtask

  task automatic test_back_to_back();
    drive_load(32'h500, 5'd13);
    step();
    mem_ack = 1; mem_rdata = 32'h0000_0501;
    step();
    drive_load(32'h504, 5'd14);
    mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
    #1;
    total_cnt++; if (readdata_w !== 32'h0000_0501) $display("FAIL b2b_first: got %h want 00000501", readdata_w); else pass_cnt++;
    total_cnt++; if ({mem_req, stall} !== 2'b01) $display("FAIL b2b_gap: got req/stall=%b want 01", {mem_req, stall}); else pass_cnt++;
    step();
    mem_rdata = 32'h0000_0505;
    #1;
    total_cnt++; if ({mem_req, mem_addr} !== {1'b1, 32'h504})
      $display("FAIL b2b_second_req: got req=%b addr=%h want 1/00000504", mem_req, mem_addr); else pass_cnt++;
    step();
    mem_ack = 0;
    clear_m();
    total_cnt++; if (readdata_w !== 32'h0000_0505 || writereg_w !== 5'd14)
      $display("FAIL b2b_second: got rdata=%h rd=%0d want 00000505/14", readdata_w, writereg_w); else pass_cnt++;
    step();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_timeout();
    test_reset_mid_access();
    test_align();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
